// File: rtl/logit_argmax.sv
// logit_argmax -- sequential argmax over a bank of signed logits.
//
// A job is started by a one-cycle start in IDLE: the whole logits_in vector
// is captured into an internal bank, then one class is examined per cycle in
// index order. The winning index, its value and the gap to the runner-up are
// presented with out_valid and held until out_ready is seen.
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   asynchronous, active-high reset
//   start      in   request to classify logits_in (honoured in IDLE only)
//   logits_in  in   NUM_CLASSES signed DATA_WIDTH logits, element 0 first
//   busy       out  high in SCAN and DONE
//   out_valid  out  result valid (DONE), held until accepted
//   out_ready  in   consumer accepts result when high with out_valid
//   class_idx  out  index of the maximum logit (lowest index on ties)
//   top_logit  out  value of the maximum logit
//   margin     out  top-1 minus top-2, unsigned
module logit_argmax #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CLASSES = 10,
    parameter int IDX_WIDTH   = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    start,
    input  logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0]  logits_in,
    output logic                                    busy,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [IDX_WIDTH-1:0]                    class_idx,
    output logic signed [DATA_WIDTH-1:0]            top_logit,
    output logic [DATA_WIDTH-1:0]                   margin
);

    localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CW-1:0] LAST = CW'(NUM_CLASSES - 1);
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                                 r_state, w_state_nxt;
    logic [0:NUM_CLASSES-1][DATA_WIDTH-1:0] r_bank;
    logic [CW-1:0]                          r_cnt;
    logic signed [DATA_WIDTH-1:0]           r_best, r_second;
    logic [CW-1:0]                          r_idx;

    logic signed [DATA_WIDTH-1:0]           w_cur;
    logic signed [DATA_WIDTH-1:0]           w_best_nxt, w_second_nxt;
    logic [CW-1:0]                          w_idx_nxt;
    logic                                   w_last;
    logic [DATA_WIDTH:0]                    w_diff;
    logic [DATA_WIDTH-1:0]                  w_margin;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)     w_state_nxt = SCAN;
            SCAN:    if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default:                w_state_nxt = IDLE;
        endcase
    end

    // Outputs decode registered state only: no start/out_ready feedthrough.
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);

    // ---------------- scan datapath ----------------
    assign w_cur  = $signed(r_bank[r_cnt]);
    assign w_last = (r_cnt == LAST);

    // Strict '>' keeps the earliest index on a tie; the tied value then
    // lands in second, which yields margin 0.
    always_comb begin
        w_best_nxt   = r_best;
        w_second_nxt = r_second;
        w_idx_nxt    = r_idx;
        if (r_cnt == '0) begin
            w_best_nxt   = w_cur;
            w_second_nxt = MIN_VAL;
            w_idx_nxt    = '0;
        end else if (w_cur > r_best) begin
            w_second_nxt = r_best;
            w_best_nxt   = w_cur;
            w_idx_nxt    = r_cnt;
        end else if (w_cur > r_second) begin
            w_second_nxt = w_cur;
        end
    end

    // One guard bit so best - second cannot wrap; best >= second always holds,
    // so the sign bit stays clear and the low DATA_WIDTH bits are exact.
    assign w_diff = {w_best_nxt[DATA_WIDTH-1], w_best_nxt}
                  - {w_second_nxt[DATA_WIDTH-1], w_second_nxt};

    always_comb begin
        w_margin = w_diff[DATA_WIDTH-1:0];
        if (NUM_CLASSES == 1 || w_diff[DATA_WIDTH]) w_margin = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank    <= '0;
            r_cnt     <= '0;
            r_best    <= '0;
            r_second  <= '0;
            r_idx     <= '0;
            class_idx <= '0;
            top_logit <= '0;
            margin    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bank <= logits_in;
                        r_cnt  <= '0;
                    end
                end
                SCAN: begin
                    r_best   <= w_best_nxt;
                    r_second <= w_second_nxt;
                    r_idx    <= w_idx_nxt;
                    r_cnt    <= r_cnt + 1'b1;
                    if (w_last) begin
                        // Result registers change only here, so they stay
                        // stable through DONE, IDLE and the next SCAN.
                        r_cnt     <= '0;
                        class_idx <= IDX_WIDTH'(w_idx_nxt);
                        top_logit <= w_best_nxt;
                        margin    <= w_margin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_logit_argmax.sv
// Directed bench for logit_argmax with NUM_CLASSES=4, DATA_WIDTH=16.
module tb_logit_argmax;

    localparam int N = 4;
    localparam int W = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [0:N-1][W-1:0]   logits_in;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [1:0]            class_idx;
    logic signed [W-1:0]   top_logit;
    logic [W-1:0]          margin;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    logit_argmax #(.DATA_WIDTH(W), .NUM_CLASSES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .logits_in (logits_in),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .class_idx (class_idx),
        .top_logit (top_logit),
        .margin    (margin)
    );

    typedef struct {
        logic [0:N-1][W-1:0] logits;
        logic [1:0]          idx;
        logic [W-1:0]        top;
        logic [W-1:0]        mrg;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    // Pulse start with v.logits; returns the number of rising edges after the
    // start-sampling edge until out_valid is seen (bounded).
    task automatic launch(input vec_t v, output int cyc);
        @(negedge clk);
        logits_in = v.logits;
        start     = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_start", {31'd0, busy}, 32'd1);
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic chk_result(input vec_t v, input string nm, input int cyc);
        chk({nm, "_latency"}, 32'(cyc),       32'd4);
        chk({nm, "_idx"},     {30'd0, class_idx}, {30'd0, v.idx});
        chk({nm, "_top"},     {16'd0, top_logit}, {16'd0, v.top});
        chk({nm, "_margin"},  {16'd0, margin},    {16'd0, v.mrg});
    endtask

    // Full job with out_ready held high; ends in IDLE right after the
    // handshake edge so the next launch is back-to-back.
    task automatic run_job(input vec_t v, input string nm);
        int cyc;
        launch(v, cyc);
        chk_result(v, nm, cyc);
        @(posedge clk); #1;
        chk({nm, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
        chk({nm, "_idle"},       {31'd0, busy},      32'd0);
    endtask

    initial begin
        int cyc;
        vec_t v;

        tbl[0] = '{{16'h0100, 16'h7FFF, 16'h8000, 16'h1000}, 2'd1, 16'h7FFF, 16'h6FFF};
        tbl[1] = '{{16'h0200, 16'h0200, 16'h0100, 16'h0200}, 2'd0, 16'h0200, 16'h0000};
        tbl[2] = '{{16'h8000, 16'h8000, 16'h8000, 16'h8000}, 2'd0, 16'h8000, 16'h0000};
        tbl[3] = '{{16'h7FFF, 16'h8000, 16'h8000, 16'h8000}, 2'd0, 16'h7FFF, 16'hFFFF};
        tbl[4] = '{{16'h8001, 16'h8000, 16'hFFFF, 16'hFFFE}, 2'd2, 16'hFFFF, 16'h0001};
        tbl[5] = '{{16'h0010, 16'h0020, 16'h0030, 16'h0040}, 2'd3, 16'h0040, 16'h0010};
        tbl[6] = '{{16'h0040, 16'h0030, 16'h0020, 16'h0010}, 2'd0, 16'h0040, 16'h0010};
        tbl[7] = '{{16'h0001, 16'h0005, 16'h0003, 16'h0005}, 2'd1, 16'h0005, 16'h0000};

        // Reset with start held high: must stay idle with zeroed outputs.
        rst       = 1'b1;
        start     = 1'b1;
        out_ready = 1'b1;
        logits_in = tbl[0].logits;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy},      32'd0);
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_idx",    {30'd0, class_idx}, 32'd0);
        chk("rst_top",    {16'd0, top_logit}, 32'd0);
        chk("rst_margin", {16'd0, margin},    32'd0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;

        // Table: consecutive entries run back-to-back (start the cycle after
        // the handshake).
        for (int i = 0; i < 8; i++) run_job(tbl[i], $sformatf("vec%0d", i));

        // Stall in DONE: start pulses and new logits must not disturb anything.
        out_ready = 1'b0;
        launch(tbl[0], cyc);
        chk_result(tbl[0], "stall", cyc);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            logits_in = tbl[k % 8].logits ^ {N{16'h5A5A}};
            start     = k[0];
            @(posedge clk); #1;
            chk("stall_busy",  {31'd0, busy},      32'd1);
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_idx",   {30'd0, class_idx}, 32'd1);
            chk("stall_top",   {16'd0, top_logit}, 32'h7FFF);
            chk("stall_mrg",   {16'd0, margin},    32'h6FFF);
        end
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release_valid", {31'd0, out_valid}, 32'd0);
        chk("stall_release_busy",  {31'd0, busy},      32'd0);

        // Results must hold through a following SCAN until the new DONE.
        @(negedge clk);
        logits_in = tbl[5].logits;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("scan_hold_top", {16'd0, top_logit}, 32'h7FFF);
        @(posedge clk); #1;

        // Asynchronous reset two cycles into SCAN discards the job at once.
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy",   {31'd0, busy},      32'd0);
        chk("midrst_valid",  {31'd0, out_valid}, 32'd0);
        chk("midrst_idx",    {30'd0, class_idx}, 32'd0);
        chk("midrst_top",    {16'd0, top_logit}, 32'd0);
        chk("midrst_margin", {16'd0, margin},    32'd0);
        @(negedge clk);
        rst = 1'b0;
        v = tbl[4];
        run_job(v, "post_rst");
        run_job(tbl[6], "post_rst_b2b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/logit_argmax.md
LOGIT_ARGMAX -- requirements
Module: logit_argmax

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, logit width (signed Q1.15).
REQ-002 SHALL have parameter NUM_CLASSES, default 10, number of logits (legal range 1..256).
REQ-003 SHALL have parameter IDX_WIDTH, default max(1,$clog2(NUM_CLASSES)), class index width.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port start  input  1  single-cycle request to classify the current logits_in.
REQ-007 SHALL have port logits_in  input  signed DATA_WIDTH x [0:NUM_CLASSES-1]  logits from the classification head.
REQ-008 SHALL have port busy  output  1  high in SCAN and DONE.
REQ-009 SHALL have port out_valid  output  1  result valid, held until accepted.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result when high with out_valid.
REQ-011 SHALL have port class_idx  output  IDX_WIDTH  index of the maximum logit.
REQ-012 SHALL have port top_logit  output  signed DATA_WIDTH  value of the maximum logit.
REQ-013 SHALL have port margin  output  unsigned DATA_WIDTH  top-1 minus top-2 logit.

Function
REQ-014 SHALL implement states IDLE, SCAN, DONE; busy=0 only in IDLE; out_valid=1 only in DONE.
REQ-015 SHALL, in IDLE with start=1, copy all logits_in into an internal register bank, clear scan counter, enter SCAN; logits_in is not sampled again during the job.
REQ-016 SHALL ignore start in SCAN and DONE (no restart, no queuing).
REQ-017 SHALL, in SCAN, process exactly one class per cycle in index order 0..NUM_CLASSES-1, using signed comparison.
REQ-018 SHALL load class 0 as best (value and index) and set second-best to -2^(DATA_WIDTH-1).
REQ-019 SHALL, for class k>0: if logit > best, second=best then best=logit, idx=k; else if logit > second, second=logit.
REQ-020 SHALL resolve ties to the lowest index (equal logit never replaces best); an equal logit becomes second, giving margin 0.
REQ-021 SHALL enter DONE on the edge that processes class NUM_CLASSES-1; out_valid rises NUM_CLASSES cycles after the edge sampling start.
REQ-022 SHALL compute margin = best - second at DATA_WIDTH+1 bits, exact (never negative, fits DATA_WIDTH unsigned); margin=0 when NUM_CLASSES=1.
REQ-023 SHALL hold class_idx, top_logit, margin stable from entry to DONE until the handshake completes.
REQ-024 SHALL, in DONE with out_ready=1, complete the handshake and return to IDLE next edge; out_valid deasserts that edge.
REQ-025 SHALL keep class_idx/top_logit/margin at their last values in IDLE and SCAN (updated only on entry to DONE).
REQ-026 SHALL accept start in the cycle immediately after returning to IDLE (back-to-back jobs: one idle cycle minimum between jobs).
REQ-027 SHALL use no combinational path from start or out_ready to any output.

Reset
REQ-028 SHALL, on rst=1 at any time (including mid-SCAN or in DONE), immediately force state IDLE, busy=0, out_valid=0, class_idx=0, top_logit=0, margin=0, clear counter and internal bank; an in-progress job is discarded.
REQ-029 SHALL ignore start while rst=1; first job accepted on the first rising edge with rst=0 and start=1.

Verification (NUM_CLASSES=4, DATA_WIDTH=16 bench)
REQ-030 Logits {0x0100,0x7FFF,0x8000,0x1000}, start, out_ready=1 -> out_valid 4 cycles after start; class_idx=1, top_logit=0x7FFF, margin=0x6FFF.
REQ-031 Logits {0x0200,0x0200,0x0100,0x0200} -> class_idx=0, top_logit=0x0200, margin=0.
REQ-032 Logits all 0x8000 -> class_idx=0, top_logit=0x8000, margin=0; logits {0x7FFF,0x8000,0x8000,0x8000} -> margin=0xFFFF.
REQ-033 out_ready=0 for 10 cycles after out_valid, start pulsed and logits_in changed meanwhile -> outputs unchanged, busy=1, no new job; out_ready=1 -> IDLE next edge.
REQ-034 rst asserted 2 cycles into SCAN -> all outputs 0 immediately, busy=0; new start after release -> correct result for new logits.
REQ-035 Two jobs back-to-back with start asserted the cycle after handshake -> both results correct, second out_valid 4 cycles after its start.
